// File: rtl/mbist_pkg.sv
// Shared types and March algorithm tables for the memory BIST/BISR controller.
package mbist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CMP,
    NEXT_ADDR,
    NEXT_ELEM,
    DONE
  } state_t;

  // One March element: direction plus up to two operations.
  // Each op is a write/read flag and the background bit (0 = all-0, 1 = all-1).
  // For reads the background is the expected data, for writes the data written.
  typedef struct packed {
    logic down;
    logic two_ops;
    logic op0_wr;
    logic op0_val;
    logic op1_wr;
    logic op1_val;
  } march_elem_t;

  localparam logic MARCH_MATS   = 1'b0;
  localparam logic MARCH_CMINUS = 1'b1;

  localparam logic [2:0] MATS_LAST_ELEM   = 3'd2;
  localparam logic [2:0] CMINUS_LAST_ELEM = 3'd5;

  // Field order: {down, two_ops, op0_wr, op0_val, op1_wr, op1_val}; unused slots are zero.
  localparam march_elem_t MATS_TBL [8] = '{
    6'b001000,  // up(w0)
    6'b010011,  // up(r0,w1)
    6'b110110,  // down(r1,w0)
    6'b000000,
    6'b000000,
    6'b000000,
    6'b000000,
    6'b000000
  };

  localparam march_elem_t CMINUS_TBL [8] = '{
    6'b001000,  // up(w0)
    6'b010011,  // up(r0,w1)
    6'b010110,  // up(r1,w0)
    6'b110011,  // down(r0,w1)
    6'b110110,  // down(r1,w0)
    6'b100000,  // down(r0)
    6'b000000,
    6'b000000
  };

  function automatic march_elem_t elem_lookup(input logic sel, input logic [2:0] idx);
    return sel ? CMINUS_TBL[idx] : MATS_TBL[idx];
  endfunction

  function automatic logic [2:0] last_elem_idx(input logic sel);
    return sel ? CMINUS_LAST_ELEM : MATS_LAST_ELEM;
  endfunction

endpackage

// File: rtl/mbisr_remap_table.sv
// Spare-row remap table: appends faulty addresses in order and looks up a
// single address against all valid entries (lowest index wins).
module mbisr_remap_table
  import mbist_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int NUM_SPARES = 2,
  parameter int IDX_W      = 1,
  parameter int CNT_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              append,
  input  logic [ADDR_W-1:0] append_addr,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0]     entry [NUM_SPARES];
  logic [NUM_SPARES-1:0] valid;
  logic [CNT_W-1:0]      cnt;

  assign full  = (cnt == CNT_W'(NUM_SPARES));
  assign count = cnt;

  // Valid bits and fill count; the next free slot is always entry[cnt].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      cnt   <= '0;
    end else if (clear) begin
      valid <= '0;
      cnt   <= '0;
    end else if (append && !full) begin
      for (int i = 0; i < NUM_SPARES; i++) begin
        if (cnt == CNT_W'(i)) valid[i] <= 1'b1;
      end
      cnt <= cnt + 1'b1;
    end
  end

  // Entry payload; meaningless until its valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (append && !full) begin
      for (int i = 0; i < NUM_SPARES; i++) begin
        if (cnt == CNT_W'(i)) entry[i] <= append_addr;
      end
    end
  end

  // Associative lookup; scanning downward lets the lowest matching index win.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SPARES - 1; i >= 0; i--) begin
      if (valid[i] && (entry[i] == lookup_addr)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mbist_mbisr_ctrl.sv
// March-based memory BIST with spare-row repair logging and functional remap.
module mbist_mbisr_ctrl
  import mbist_pkg::*;
#(
  parameter int  ADDR_W     = 4,
  parameter int  DATA_W     = 8,
  parameter int  NUM_SPARES = 2,
  localparam int IDX_W      = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1,
  localparam int CNT_W      = $clog2(NUM_SPARES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              march_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [ADDR_W-1:0] func_addr,
  output logic              remap_hit,
  output logic [IDX_W-1:0]  remap_idx,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic              repaired,
  output logic [CNT_W-1:0]  fault_cnt
);

  function automatic logic [DATA_W-1:0] background(input logic v);
    return {DATA_W{v}};
  endfunction

  state_t            state, state_nxt;
  logic              march_r;
  logic [2:0]        elem_r, elem_nxt;
  logic              op_r, op_nxt;
  logic [ADDR_W-1:0] addr_r, addr_nxt;
  logic              fail_r;

  march_elem_t       cur, nxt_e;
  logic              cur_val;
  logic              last_addr;
  logic              mismatch;
  logic              launch, advance, set_fail;
  logic              tbl_clear, tbl_append;
  logic              tbl_hit, tbl_full;
  logic [IDX_W-1:0]  tbl_idx;
  logic [CNT_W-1:0]  tbl_cnt;
  logic [ADDR_W-1:0] tbl_lookup;

  // Current element / operation decode.
  always_comb begin
    cur       = elem_lookup(march_r, elem_r);
    cur_val   = op_r ? cur.op1_val : cur.op0_val;
    last_addr = cur.down ? (addr_r == '0) : (addr_r == '1);
    mismatch  = (mem_rdata != background(cur_val));
  end

  // Next-state logic; address and element advance are folded into the last op cycle.
  always_comb begin
    state_nxt  = state;
    elem_nxt   = elem_r;
    op_nxt     = op_r;
    addr_nxt   = addr_r;
    nxt_e      = cur;
    launch     = 1'b0;
    advance    = 1'b0;
    set_fail   = 1'b0;
    tbl_clear  = 1'b0;
    tbl_append = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          launch    = 1'b1;
          tbl_clear = 1'b1;
          nxt_e     = elem_lookup(march_sel, 3'd0);
          elem_nxt  = 3'd0;
          op_nxt    = 1'b0;
          addr_nxt  = nxt_e.down ? '1 : '0;
          state_nxt = nxt_e.op0_wr ? WR : RD;
        end
      end
      WR:  advance = 1'b1;
      RD:  state_nxt = CMP;
      CMP: begin
        advance = 1'b1;
        if (mismatch && !tbl_hit) begin
          if (!tbl_full) begin
            tbl_append = 1'b1;
          end else begin
            // More distinct faults than spares: abandon the test.
            set_fail  = 1'b1;
            advance   = 1'b0;
            state_nxt = DONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (advance) begin
      if (cur.two_ops && !op_r) begin
        op_nxt    = 1'b1;
        state_nxt = cur.op1_wr ? WR : RD;
      end else if (!last_addr) begin
        op_nxt    = 1'b0;
        addr_nxt  = cur.down ? (addr_r - 1'b1) : (addr_r + 1'b1);
        state_nxt = cur.op0_wr ? WR : RD;
      end else if (elem_r != last_elem_idx(march_r)) begin
        nxt_e     = elem_lookup(march_r, elem_r + 3'd1);
        elem_nxt  = elem_r + 3'd1;
        op_nxt    = 1'b0;
        addr_nxt  = nxt_e.down ? '1 : '0;
        state_nxt = nxt_e.op0_wr ? WR : RD;
      end else begin
        state_nxt = DONE;
      end
    end
  end

  // Controller registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      march_r <= MARCH_MATS;
      elem_r  <= '0;
      op_r    <= 1'b0;
      addr_r  <= '0;
      fail_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      elem_r <= elem_nxt;
      op_r   <= op_nxt;
      addr_r <= addr_nxt;
      if (launch) begin
        march_r <= march_sel;
        fail_r  <= 1'b0;
      end else if (set_fail) begin
        fail_r <= 1'b1;
      end
    end
  end

  // During the test the table answers "already logged?"; otherwise it serves functional remap.
  assign tbl_lookup = busy ? addr_r : func_addr;

  mbisr_remap_table #(
    .ADDR_W     (ADDR_W),
    .NUM_SPARES (NUM_SPARES),
    .IDX_W      (IDX_W),
    .CNT_W      (CNT_W)
  ) u_remap_table (
    .clk         (clk),
    .rst         (rst),
    .clear       (tbl_clear),
    .append      (tbl_append),
    .append_addr (addr_r),
    .lookup_addr (tbl_lookup),
    .hit         (tbl_hit),
    .idx         (tbl_idx),
    .full        (tbl_full),
    .count       (tbl_cnt)
  );

  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign fail      = fail_r;
  assign fault_cnt = tbl_cnt;
  assign repaired  = done & ~fail_r & (tbl_cnt != '0);
  assign remap_hit = ~busy & tbl_hit;
  assign remap_idx = busy ? '0 : tbl_idx;
  assign mem_addr  = addr_r;
  assign mem_we    = (state == WR);
  assign mem_re    = (state == RD);
  assign mem_wdata = (state == WR) ? background(cur_val) : '0;

endmodule

// File: tb/tb_mbist_mbisr_ctrl.sv
// Bench for mbist_mbisr_ctrl: faulty SRAM model plus a string-driven March reference model.
module tb_mbist_mbisr_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int NS    = 2;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          march_sel = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] func_addr = '0;
  logic          remap_hit;
  logic          remap_idx;
  logic          busy;
  logic          done;
  logic          fail;
  logic          repaired;
  logic [1:0]    fault_cnt;

  always #5 clk = ~clk;

  mbist_mbisr_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_SPARES(NS)) dut (
    .clk(clk), .rst(rst), .start(start), .march_sel(march_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .func_addr(func_addr), .remap_hit(remap_hit),
    .remap_idx(remap_idx), .busy(busy), .done(done), .fail(fail),
    .repaired(repaired), .fault_cnt(fault_cnt)
  );

  // Fault configuration shared by the SRAM model and the reference model.
  logic [DW-1:0] sa0 [DEPTH];
  logic [DW-1:0] sa1 [DEPTH];
  bit            cpl_en = 0;
  int            cpl_aggr = 0;
  int            cpl_vict = 0;

  function automatic logic [DW-1:0] rd_fault(input int a, input logic [DW-1:0] v);
    return (v & ~sa0[a[3:0]]) | sa1[a[3:0]];
  endfunction

  function automatic bit cpl_flip(input int a, input logic [DW-1:0] d);
    return cpl_en && (a == cpl_aggr) && (d == 8'hFF);
  endfunction

  // SRAM model with 1-cycle read latency.
  logic [DW-1:0] mem_dut [DEPTH];
  always @(posedge clk) begin
    if (mem_we) begin
      mem_dut[mem_addr] <= mem_wdata;
      if (cpl_flip(int'(mem_addr), mem_wdata)) mem_dut[cpl_vict[3:0]] <= ~mem_dut[cpl_vict[3:0]];
    end
    if (mem_re) mem_rdata <= rd_fault(int'(mem_addr), mem_dut[mem_addr]);
  end

  int we_tot = 0;
  int re_tot = 0;
  always @(posedge clk) begin
    if (mem_we) we_tot++;
    if (mem_re) re_tot++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model results.
  int exp_list[$];
  bit exp_fail;
  int exp_nwe, exp_nre, exp_dcyc;
  int last_cyc;

  function automatic bit in_list(input int a);
    foreach (exp_list[i]) if (exp_list[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Interprets the March notation directly: "U"/"D" then op pairs like "r0","w1".
  task automatic model_run(input logic sel);
    string         el[$];
    string         s;
    logic [DW-1:0] m [DEPTH];
    logic [DW-1:0] bgv;
    byte           op;
    int            cyc;
    int            a;
    bit            abort;
    if (sel) el = '{"Uw0", "Ur0w1", "Ur1w0", "Dr0w1", "Dr1w0", "Dr0"};
    else     el = '{"Uw0", "Ur0w1", "Dr1w0"};
    foreach (m[i]) m[i] = '0;
    exp_list.delete();
    exp_fail = 0; exp_nwe = 0; exp_nre = 0; cyc = 0; abort = 0;
    foreach (el[k]) begin
      s = el[k];
      for (int n = 0; n < DEPTH && !abort; n++) begin
        a = (s.getc(0) == "D") ? DEPTH - 1 - n : n;
        for (int p = 1; p + 1 < s.len() && !abort; p += 2) begin
          op  = s.getc(p);
          bgv = (s.getc(p + 1) == "1") ? 8'hFF : 8'h00;
          if (op == "w") begin
            cyc += 1; exp_nwe++;
            m[a] = bgv;
            if (cpl_flip(a, bgv)) m[cpl_vict] = ~m[cpl_vict];
          end else begin
            cyc += 2; exp_nre++;
            if (rd_fault(a, m[a]) != bgv && !in_list(a)) begin
              if (exp_list.size() < NS) exp_list.push_back(a);
              else begin exp_fail = 1; abort = 1; end
            end
          end
        end
      end
    end
    exp_dcyc = cyc + 1;
  endtask

  task automatic clear_faults();
    foreach (sa0[i]) begin sa0[i] = '0; sa1[i] = '0; end
    cpl_en = 0;
  endtask

  // Launches (unless already armed by a held start), waits for done, checks against the model.
  task automatic run_check(input string tag, input logic sel, input bit started,
                           input bit toggle, input bit hold);
    int cyc, we0, re0, ei;
    bit eh;
    model_run(sel);
    if (!started) @(negedge clk);
    march_sel = sel;
    start = 1'b1;
    we0 = we_tot; re0 = re_tot;
    @(posedge clk); #1;
    if (!toggle) start = 1'b0;
    check_val({tag, "_launch_busy"}, busy, 1);
    check_val({tag, "_launch_cnt"}, fault_cnt, 0);
    check_val({tag, "_launch_done"}, done, 0);
    cyc = 1;
    while (!done && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (toggle) start = 1'($urandom_range(0, 1));
    end
    start = hold;
    last_cyc = cyc;
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_cycles"}, cyc, exp_dcyc);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_fail"}, fail, int'(exp_fail));
    check_val({tag, "_fault_cnt"}, fault_cnt, exp_list.size());
    check_val({tag, "_repaired"}, repaired, int'(!exp_fail && exp_list.size() > 0));
    check_val({tag, "_we_cnt"}, we_tot - we0, exp_nwe);
    check_val({tag, "_re_cnt"}, re_tot - re0, exp_nre);
    if (!hold) begin
      for (int a = 0; a < DEPTH; a++) begin
        func_addr = AW'(a);
        #1;
        eh = 0; ei = 0;
        foreach (exp_list[i]) if (exp_list[i] == a && !eh) begin eh = 1; ei = i; end
        check_val($sformatf("%s_hit_%0d", tag, a), remap_hit, int'(eh));
        if (eh) check_val($sformatf("%s_idx_%0d", tag, a), remap_idx, ei);
      end
      repeat (4) @(posedge clk);
      #1;
      check_val({tag, "_quiet_we"}, we_tot - we0, exp_nwe);
      check_val({tag, "_hold_done"}, done, 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, na, a, b;
    clear_faults();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_fail", fail, 0);
    check_val("rst_repaired", repaired, 0);
    check_val("rst_fault_cnt", fault_cnt, 0);
    check_val("rst_we", mem_we, 0);
    check_val("rst_re", mem_re, 0);
    check_val("rst_hit", remap_hit, 0);
    @(negedge clk); rst = 1'b0;

    // Fault-free March C-.
    run_check("cm_clean", 1'b1, 0, 0, 0);
    check_val("cm_clean_241", last_cyc, 241);

    // Stuck-at-0 on bit 3 of address 5, MATS+.
    clear_faults(); sa0[5] = 8'h08;
    run_check("mats_sa5", 1'b0, 0, 0, 0);
    check_val("mats_sa5_113", last_cyc, 113);

    // Three faulty rows with two spares: early abort.
    clear_faults(); sa0[2] = 8'h01; sa1[9] = 8'h40; sa0[14] = 8'h80;
    run_check("cm_abort", 1'b1, 0, 0, 0);

    // Coupling: write of ones to 3 flips 4.
    clear_faults(); cpl_en = 1; cpl_aggr = 3; cpl_vict = 4;
    run_check("cm_cpl", 1'b1, 0, 0, 0);

    // Reset in the middle of a run.
    clear_faults(); sa0[1] = 8'h02;
    @(negedge clk); march_sel = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 1;
    while (cyc < 50) begin @(posedge clk); #1; cyc++; end
    check_val("rst_mid_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_val("rst_mid_busy", busy, 0);
    check_val("rst_mid_done", done, 0);
    check_val("rst_mid_fail", fail, 0);
    check_val("rst_mid_cnt", fault_cnt, 0);
    check_val("rst_mid_we", mem_we, 0);
    check_val("rst_mid_re", mem_re, 0);
    check_val("rst_mid_repaired", repaired, 0);
    @(negedge clk); rst = 1'b0;
    clear_faults();
    run_check("post_rst", 1'b1, 0, 0, 0);
    check_val("post_rst_241", last_cyc, 241);

    // start held through DONE re-runs and clears the table.
    clear_faults(); sa1[7] = 8'h10;
    run_check("hold_first", 1'b0, 0, 0, 1);
    clear_faults();
    run_check("hold_second", 1'b1, 1, 0, 0);

    // start toggling while busy must not disturb timing.
    clear_faults();
    run_check("toggle", 1'b1, 0, 1, 0);
    check_val("toggle_241", last_cyc, 241);

    // Randomized fault populations and algorithm choice.
    for (int r = 0; r < 6; r++) begin
      clear_faults();
      na = $urandom_range(0, 3);
      for (int k = 0; k < na; k++) begin
        a = $urandom_range(0, DEPTH - 1);
        b = $urandom_range(0, DW - 1);
        if ($urandom_range(0, 1) != 0) sa0[a][b] = 1'b1;
        else                           sa1[a][b] = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        cpl_en   = 1;
        cpl_aggr = $urandom_range(0, DEPTH - 1);
        cpl_vict = (cpl_aggr + $urandom_range(1, DEPTH - 1)) % DEPTH;
      end
      run_check($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mbist_mbisr_ctrl.md
Name: mbist_mbisr_ctrl

Overview:
- Parametrised memory built-in self-test and self-repair controller; successor to the fixed single-memory start/done/fail BIST top.
- Drives an external single-port synchronous SRAM through an address/data/write-enable interface.
- Runs a selectable March algorithm (MATS+ or March C-) and logs failing addresses into a spare-row remap table of NUM_SPARES entries.
- After the test it remaps functional addresses onto spares. It sits between the chip-level wrapper (start/done/fail pins) and the memory macro.

Parameters:
- ADDR_W, 4, memory address width; depth = 2**ADDR_W words.
- DATA_W, 8, memory word width; backgrounds are all-0 / all-1 of DATA_W.
- NUM_SPARES, 2, number of spare rows (remap table entries), 1..8.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; sampled only in IDLE or DONE; launches a test
- march_sel  in  1  0 = MATS+, 1 = March C-; latched at start
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_we  out  1  write enable
- mem_re  out  1  read enable; rdata is valid the following cycle
- mem_rdata  in  DATA_W  read data, 1-cycle latency
- func_addr  in  ADDR_W  functional-mode address to check for remap
- remap_hit  out  1  func_addr matches a valid table entry (combinational)
- remap_idx  out  $clog2(NUM_SPARES) or 1  index of the matching spare
- busy  out  1  test in progress
- done  out  1  test finished; held until the next start
- fail  out  1  unrepairable: more distinct faulty addresses than spares
- repaired  out  1  done with at least one spare used and fail = 0
- fault_cnt  out  $clog2(NUM_SPARES+1)  number of valid table entries

Behaviour:
- Reset: all outputs 0; table cleared; state IDLE; mem_we = mem_re = 0. Reset mid-run aborts immediately with the same values.
- Element lists:
  - MATS+: up(w0); up(r0,w1); down(r1,w0).
  - March C-: up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); down(r0).
- States: IDLE, WR, RD, CMP, NEXT_ADDR, NEXT_ELEM, DONE.
- Op timing:
  - Write: 1 cycle (WR, mem_we = 1).
  - Read: 2 cycles. RD drives mem_re; CMP compares mem_rdata with the expected background.
- Cycles per address: MATS+ 7, March C- 15. Address and element advance are folded into the last op cycle; NEXT_* are combinational decisions, not extra cycles.
- Sequence:
  - start sampled high in IDLE/DONE at cycle 0: march_sel is latched; table, done, fail, repaired, fault_cnt are cleared; busy = 1.
  - First memory op occurs at cycle 1.
  - done = 1 and busy = 0 in the cycle after the final op. For depth 16: MATS+ done at cycle 113, March C- at cycle 241.
- Direction:
  - Up elements run 0..2**ADDR_W-1; down elements run 2**ADDR_W-1..0.
  - Terminal address ends the element. Wrap-around never occurs.
- Mismatch in CMP at address A:
  - A already in table: no action.
  - A new and table not full: append A at entry fault_cnt; increment fault_cnt.
  - A new and table full: fail = 1; go to DONE next cycle (early abort, done = 1); mem_we/mem_re are 0 from then on.
- Test continues after a repairable fault; the array is still tested, not the spares.
- Remap: while not busy, remap_hit/remap_idx compare func_addr against valid entries. Lowest index wins (duplicates cannot occur). During busy, remap_hit = 0.
- repaired = done & ~fail & (fault_cnt != 0).
- start held high in DONE re-runs the test. start in any busy state is ignored.

Decomposition:
- Package mbist_pkg:
  - state enum;
  - march-element descriptor (direction, op list, expected/write backgrounds);
  - MATS+ and March C- element constant tables.
- Sub-module mbisr_remap_table: NUM_SPARES entries with valid bits; append/lookup/clear; full flag.
- The controller FSM stays in mbist_mbisr_ctrl.

Test Plan:
- Fault-free 16x8 memory model, March C- → done rises at cycle 241; fail = 0, repaired = 0, fault_cnt = 0; mem_we count = 80, mem_re count = 80.
- Stuck-at-0 on bit 3 of address 5, MATS+ → fault_cnt = 1, table[0] = 5, repaired = 1, done at cycle 113; func_addr = 5 gives remap_hit = 1, remap_idx = 0; func_addr = 6 gives remap_hit = 0.
- Stuck-at faults at addresses 2, 9, 14 with NUM_SPARES = 2, March C- → entries 2, 9 logged; fail = 1 and done = 1 the cycle after the CMP that detects address 14; no further mem_we.
- Coupling fault (write 1 to address 3 flips address 4), March C- → detected; table[0] = 4; addresses 3 and 4 are not double-logged across elements.
- rst asserted at cycle 50 of a run → all outputs 0 and mem_we = 0 within the same cycle. After release, start → full run completes normally at cycle 241.
- start held through DONE → second run clears the table; a fault-free model ends with fault_cnt = 0 and repaired = 0. Toggling start while busy has no effect on timing.
